ldst_control_seq: RTL and testbench

Hardwired control sequencer for the phase-2 datapath (`cpu_phase2`) that drives the per-step strobes for the memory-class instructions `ld`, `ldi`, `st` and `addi`. It replaces hand-sequenced strobes with an FSM that fetches, decodes the IR opcode and steps T0–T7. It adds a memory-ready handshake, illegal-opcode trapping and continuous or single-step run modes.

---
 rtl/ldst_control_seq.sv | 141 ++++++++++++++
 tb/tb_ldst_control_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ldst_control_seq.sv
// ldst_control_seq: hardwired T0-T7 control sequencer for ld/ldi/st/addi
// Optional feature macro: LDST_SEQ_MEM_WAIT_EN (T1, ld-T6, st-T7 wait for mem_ready)
// Ports:
//   clk, clr (async active-low reset), run (level start/continue)
//   ir (instruction register, opcode in top OP_W bits), mem_ready (memory handshake)
//   PCout..Yin datapath strobes, alu_op (ALU_ADD in T4)
//   state (present state), busy (not IDLE), done (final step pulse), illegal (ILL pulse)
module ldst_control_seq #(
    parameter int              IR_W    = 32,
    parameter int              OP_W    = 5,
    parameter logic [OP_W-1:0] OP_LD   = 5'b00000,
    parameter logic [OP_W-1:0] OP_LDI  = 5'b00001,
    parameter logic [OP_W-1:0] OP_ST   = 5'b00010,
    parameter logic [OP_W-1:0] OP_ADDI = 5'b01100,
    parameter logic [OP_W-1:0] ALU_ADD = 5'b00011
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            Zin,
    output logic            ZLowOut,
    output logic            PCin,
    output logic            Read,
    output logic            Write,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Gra,
    output logic            Grb,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            Cout,
    output logic            Yin,
    output logic [OP_W-1:0] alu_op,
    output logic [3:0]      state,
    output logic            busy,
    output logic            done,
    output logic            illegal
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, ILL} state_t;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_ir;
    logic            legal, is_short, is_ld, is_st, rdy;
    state_t          end_next;

    assign op_ir    = ir[IR_W-1 -: OP_W];
    assign legal    = op_ir == OP_LD || op_ir == OP_LDI || op_ir == OP_ST || op_ir == OP_ADDI;
    assign is_short = op_q == OP_LDI || op_q == OP_ADDI;
    assign is_ld    = op_q == OP_LD;
    assign is_st    = op_q == OP_ST;
    assign end_next = run ? T0 : IDLE;
    assign state    = state_q;
    assign busy     = state_q != IDLE;

`ifdef LDST_SEQ_MEM_WAIT_EN
    assign rdy = mem_ready;
    logic unused_ir;
    assign unused_ir = ^ir[IR_W-OP_W-1:0];
`else
    // Single-cycle memory: handshake is ignored
    assign rdy = 1'b1;
    logic unused_in;
    assign unused_in = ^{ir[IR_W-OP_W-1:0], mem_ready};
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            // Opcode captured as T3 is left, so T4 onward decodes a stable copy
            if (state_q == T3)
                op_q <= op_ir;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = run ? T0 : IDLE;
            T0:      state_d = T1;
            T1:      state_d = rdy ? T2 : T1;
            T2:      state_d = T3;
            T3:      state_d = legal ? T4 : ILL;
            T4:      state_d = T5;
            T5:      state_d = is_short ? end_next : T6;
            T6:      state_d = (is_ld && !rdy) ? T6 : T7;
            T7:      state_d = (is_st && !rdy) ? T7 : end_next;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        {PCout, MARin, IncPC, Zin, ZLowOut, PCin, Read, Write, MDRin} = '0;
        {MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Cout, Yin} = '0;
        alu_op  = '0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            T0: {PCout, MARin, IncPC, Zin} = '1;
            T1: {ZLowOut, PCin, Read, MDRin} = '1;
            T2: {MDRout, IRin} = '1;
            T3: {Grb, BAout, Yin} = '1;
            T4: begin
                {Cout, Zin} = '1;
                alu_op = ALU_ADD;
            end
            T5: begin
                ZLowOut = 1'b1;
                MARin   = !is_short;
                Gra     = is_short;
                Rin     = is_short;
                done    = is_short;
            end
            T6: begin
                Read  = is_ld;
                Gra   = !is_ld;
                Rout  = !is_ld;
                MDRin = 1'b1;
            end
            T7: begin
                MDRout = 1'b1;
                Gra    = is_ld;
                Rin    = is_ld;
                Write  = !is_ld;
                done   = 1'b1;
            end
            ILL: illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ldst_control_seq.sv
// tb_ldst_control_seq: directed table-driven check of the ld/ldi/st/addi sequencer
module tb_ldst_control_seq;
    localparam logic [17:0] P_PCOUT = 18'h20000, P_MARIN = 18'h10000, P_INCPC = 18'h08000;
    localparam logic [17:0] P_ZIN = 18'h04000, P_ZLOW = 18'h02000, P_PCIN = 18'h01000;
    localparam logic [17:0] P_READ = 18'h00800, P_WRITE = 18'h00400, P_MDRIN = 18'h00200;
    localparam logic [17:0] P_MDROUT = 18'h00100, P_IRIN = 18'h00080, P_GRA = 18'h00040;
    localparam logic [17:0] P_GRB = 18'h00020, P_RIN = 18'h00010, P_ROUT = 18'h00008;
    localparam logic [17:0] P_BAOUT = 18'h00004, P_COUT = 18'h00002, P_YIN = 18'h00001;
    localparam logic [31:0] I_LD = 32'h0000_0000, I_LDI = 32'h0880_0005;
    localparam logic [31:0] I_ST = 32'h1000_0000, I_ADDI = 32'h6000_0000, I_BAD = 32'hF800_0000;
`ifdef LDST_SEQ_MEM_WAIT_EN
    localparam logic LD_RDY = 1'b1;
`else
    localparam logic LD_RDY = 1'b0;
`endif

    logic clk, clr, run, mem_ready;
    logic [31:0] ir;
    logic PCout, MARin, IncPC, Zin, ZLowOut, PCin, Read, Write, MDRin;
    logic MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Cout, Yin;
    logic [4:0] alu_op;
    logic [3:0] state;
    logic busy, done, illegal;
    logic [29:0] obs;

    ldst_control_seq dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLowOut(ZLowOut),
        .PCin(PCin), .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .Yin(Yin), .alu_op(alu_op), .state(state), .busy(busy),
        .done(done), .illegal(illegal)
    );

    assign obs = {state, PCout, MARin, IncPC, Zin, ZLowOut, PCin, Read, Write, MDRin,
                  MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Cout, Yin, alu_op, busy, done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic [31:0] ir;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] b;
        logic [4:0]  a;
        logic        d;
        logic        il;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [29:0] ev(logic [3:0] s, logic [17:0] b, logic [4:0] a, logic d, logic il);
        return {s, b, a, s != 4'd0, d, il};
    endfunction

    task automatic chk(string nm, logic [29:0] got, logic [29:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(logic r, logic [31:0] i, logic m, logic [3:0] s, logic [17:0] b,
                       logic [4:0] a, logic d, logic il);
        vec_t v;
        v.run = r; v.ir = i; v.rdy = m; v.st = s; v.b = b; v.a = a; v.d = d; v.il = il;
        vecs.push_back(v);
    endtask

    task automatic fetch(logic r, logic [31:0] i, logic m);
        add(r, i, m, 4'd1, P_PCOUT | P_MARIN | P_INCPC | P_ZIN, 5'd0, 0, 0);
        add(r, i, m, 4'd2, P_ZLOW | P_PCIN | P_READ | P_MDRIN, 5'd0, 0, 0);
        add(r, i, m, 4'd3, P_MDROUT | P_IRIN, 5'd0, 0, 0);
        add(r, i, m, 4'd4, P_GRB | P_BAOUT | P_YIN, 5'd0, 0, 0);
    endtask

    task automatic t4(logic r, logic [31:0] i, logic m);
        add(r, i, m, 4'd5, P_COUT | P_ZIN, 5'b00011, 0, 0);
    endtask

    logic [3:0] wait_st [13] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd7, 4'd8};

    initial begin
        run = 0; ir = '0; mem_ready = 0; clr = 1;
        #2 clr = 0;
        #1 chk("reset", obs, '0);
        @(negedge clk) clr = 1;

        add(1, I_LDI, 1, 4'd0, '0, 5'd0, 0, 0);
        fetch(0, I_LDI, 1);
        t4(0, I_LDI, 1);
        add(0, I_LDI, 1, 4'd6, P_ZLOW | P_GRA | P_RIN, 5'd0, 1, 0);
        add(0, I_LDI, 1, 4'd0, '0, 5'd0, 0, 0);

        add(1, I_ST, 1, 4'd0, '0, 5'd0, 0, 0);
        fetch(0, I_ST, 1);
        t4(0, I_ST, 1);
        add(0, I_ST, 1, 4'd6, P_ZLOW | P_MARIN, 5'd0, 0, 0);
        add(0, I_ST, 1, 4'd7, P_GRA | P_ROUT | P_MDRIN, 5'd0, 0, 0);
        add(0, I_ST, 1, 4'd8, P_MDROUT | P_WRITE, 5'd0, 1, 0);
        add(0, I_ST, 1, 4'd0, '0, 5'd0, 0, 0);

        add(1, I_BAD, 1, 4'd0, '0, 5'd0, 0, 0);
        fetch(0, I_BAD, 1);
        add(0, I_BAD, 1, 4'd9, '0, 5'd0, 0, 1);
        add(0, I_BAD, 1, 4'd0, '0, 5'd0, 0, 0);

        add(1, I_ADDI, 1, 4'd0, '0, 5'd0, 0, 0);
        fetch(1, I_ADDI, 1);
        t4(1, I_ADDI, 1);
        add(1, I_ADDI, 1, 4'd6, P_ZLOW | P_GRA | P_RIN, 5'd0, 1, 0);
        fetch(1, I_ADDI, 1);
        t4(1, I_ADDI, 1);
        add(0, I_ADDI, 1, 4'd6, P_ZLOW | P_GRA | P_RIN, 5'd0, 1, 0);
        add(0, I_ADDI, 1, 4'd0, '0, 5'd0, 0, 0);

        add(1, I_LD, LD_RDY, 4'd0, '0, 5'd0, 0, 0);
        fetch(0, I_LD, LD_RDY);
        t4(0, I_LD, LD_RDY);
        add(0, I_LD, LD_RDY, 4'd6, P_ZLOW | P_MARIN, 5'd0, 0, 0);
        add(0, I_LD, LD_RDY, 4'd7, P_READ | P_MDRIN, 5'd0, 0, 0);
        add(0, I_LD, LD_RDY, 4'd8, P_MDROUT | P_GRA | P_RIN, 5'd0, 1, 0);
        add(0, I_LD, LD_RDY, 4'd0, '0, 5'd0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            run = vecs[i].run; ir = vecs[i].ir; mem_ready = vecs[i].rdy;
            #1 chk($sformatf("row%0d", i), obs, ev(vecs[i].st, vecs[i].b, vecs[i].a, vecs[i].d, vecs[i].il));
        end

        @(negedge clk) begin run = 1; ir = I_LD; mem_ready = 1; end
        @(negedge clk) run = 0;
        repeat (6) @(negedge clk);
        #1 chk("ld_t6_before_reset", obs, ev(4'd7, P_READ | P_MDRIN, 5'd0, 0, 0));
        #2 clr = 0;
        #1 chk("reset_mid_op", obs, '0);
        @(negedge clk) clr = 1;
        repeat (2) @(negedge clk);
        #1 chk("idle_after_reset", obs, '0);

`ifdef LDST_SEQ_MEM_WAIT_EN
        @(negedge clk) begin run = 1; ir = I_LD; mem_ready = 0; end
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            run = 0;
            mem_ready = (c == 5 || c == 12);
            #1 chk($sformatf("wait_c%0d", c), {26'd0, state, Read & MDRin, done, busy},
                   {26'd0, wait_st[c-1], wait_st[c-1] == 4'd2 || wait_st[c-1] == 4'd7, c == 13, 1'b1});
        end
        @(negedge clk);
        #1 chk("wait_end_idle", obs, '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
